cap_line_writer: RTL and testbench
==================================

CAP_LINE_WRITER -- requirements
Module: cap_line_writer

Interface
REQ-001 Parameter BURST_LEN, default 8, SDRAM write burst length in 16-bit words (power of two, 2..256).
REQ-002 Parameter SCR_SIZE_BIT, default 12, width of pixel-column counters and line-size input.
REQ-003 i_clk  in  1  SDRAM-domain clock; the only clock.
REQ-004 i_reset_n  in  1  reset; synchronous, active-low.
REQ-005 i_line_start  in  1  one-cycle pulse; a captured line is ready in the FIFO; already synchronised.
REQ-006 i_line  in  9  line number; sampled on i_line_start.
REQ-007 i_x_size  in  SCR_SIZE_BIT  pixels per line; sampled on i_line_start.
REQ-008 i_fifo_data  in  12  show-ahead FIFO head pixel.
REQ-009 i_fifo_usedw  in  9  FIFO fill level, read side.
REQ-010 o_fifo_rdreq  out  1  FIFO pop.
REQ-011 o_burst_req  out  1  burst request to SDRAM controller.
REQ-012 o_burst_addr  out  9+SCR_SIZE_BIT  {line, start column}.
REQ-013 o_burst_len  out  9  words in this burst (1..BURST_LEN).
REQ-014 i_burst_ack  in  1  one-cycle controller acceptance of o_burst_req.
REQ-015 i_data_next  in  1  controller consumes o_wr_data this cycle.
REQ-016 o_wr_data  out  16  {4'b0, i_fifo_data}.
REQ-017 o_line_done  out  1  one-cycle pulse; all pixels of line written.
REQ-018 o_busy  out  1  high in any state except IDLE.
REQ-019 o_overrun  out  1  sticky; i_line_start seen while busy.

Function
REQ-020 FSM states IDLE, WAIT_DATA, REQ, BURST, DONE.
REQ-021 IDLE: on i_line_start with i_x_size!=0, latch line/size, column:=0, go WAIT_DATA; i_x_size==0 goes DONE directly.
REQ-022 WAIT_DATA: len := min(BURST_LEN, size-column); go REQ when i_fifo_usedw >= len.
REQ-023 REQ: o_burst_req=1, o_burst_addr={line,column}, o_burst_len=len held stable until i_burst_ack; then go BURST.
REQ-024 BURST: o_fifo_rdreq = i_data_next (combinational); word counter increments per i_data_next; i_data_next with i_fifo_usedw==0 is ignored (no pop).
REQ-025 After len words: column += len; column==size goes DONE, else WAIT_DATA.
REQ-026 DONE: o_line_done=1 for one cycle, return IDLE.
REQ-027 Column arithmetic SCR_SIZE_BIT wide, no wrap; size-column never negative.
REQ-028 i_line_start outside IDLE: set o_overrun, current line continues, new start dropped.
REQ-029 i_burst_ack outside REQ and i_data_next outside BURST are ignored.
REQ-030 Latency IDLE->o_burst_req: 2 cycles minimum (WAIT_DATA then REQ).

Reset
REQ-031 While i_reset_n=0 at a clock edge: state IDLE; o_burst_req, o_fifo_rdreq, o_line_done, o_busy, o_overrun = 0; o_burst_addr, o_burst_len, counters = 0.
REQ-032 Reset mid-burst abandons the line without further pops; no recovery pulse.

Structure
REQ-033 Shared package holds FSM state encoding, address-width constant (9+SCR_SIZE_BIT) and BURST_LEN default.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 x_size=16, BURST_LEN=8, FIFO prefilled 16: two bursts addr col 0 then 8, len 8 each, 16 pops, one o_line_done.
REQ-036 x_size=13: bursts len 8 then 5 (col 8), 13 pops, o_line_done.
REQ-037 usedw held at 5 with len 8 pending: o_burst_req stays 0 until usedw reaches 8.
REQ-038 i_line_start during BURST: o_overrun=1, current line completes, no extra burst.
REQ-039 Reset asserted mid-burst after 3 words: next edge all outputs 0, state IDLE, no further rdreq.
REQ-040 x_size=0: o_line_done one cycle after start, zero bursts, zero pops.

Source files
------------

// File: rtl/cap_line_writer_pkg.sv
// Shared constants and FSM state encoding for the capture line writer.
package cap_line_writer_pkg;

  localparam int BURST_LEN_DEF    = 8;
  localparam int SCR_SIZE_BIT_DEF = 12;
  localparam int LINE_W           = 9;
  localparam int ADDR_W_DEF       = LINE_W + SCR_SIZE_BIT_DEF;

  function automatic int addr_w(input int scr_size_bit);
    return LINE_W + scr_size_bit;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_REQ       = 3'd2,
    ST_BURST     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/cap_line_writer_if.sv
// Bundle between the line writer, the capture FIFO read side and the SDRAM write controller.
interface cap_line_writer_if
  import cap_line_writer_pkg::*;
#(
  parameter int SCR_SIZE_BIT = SCR_SIZE_BIT_DEF
) ();

  logic                             i_line_start;
  logic [LINE_W-1:0]                i_line;
  logic [SCR_SIZE_BIT-1:0]          i_x_size;
  logic [11:0]                      i_fifo_data;
  logic [8:0]                       i_fifo_usedw;
  logic                             o_fifo_rdreq;
  logic                             o_burst_req;
  logic [addr_w(SCR_SIZE_BIT)-1:0]  o_burst_addr;
  logic [8:0]                       o_burst_len;
  logic                             i_burst_ack;
  logic                             i_data_next;
  logic [15:0]                      o_wr_data;
  logic                             o_line_done;
  logic                             o_busy;
  logic                             o_overrun;

  modport master (
    input  i_line_start, i_line, i_x_size, i_fifo_data, i_fifo_usedw,
    input  i_burst_ack, i_data_next,
    output o_fifo_rdreq, o_burst_req, o_burst_addr, o_burst_len,
    output o_wr_data, o_line_done, o_busy, o_overrun
  );

  modport slave (
    output i_line_start, i_line, i_x_size, i_fifo_data, i_fifo_usedw,
    output i_burst_ack, i_data_next,
    input  o_fifo_rdreq, o_burst_req, o_burst_addr, o_burst_len,
    input  o_wr_data, o_line_done, o_busy, o_overrun
  );

endinterface

// File: rtl/cap_line_writer.sv
// Moves one captured line from the show-ahead FIFO into SDRAM as a series of bursts.
//   state      | meaning
//   IDLE       | waiting for a line start
//   WAIT_DATA  | sizing next burst, waiting for enough FIFO words
//   REQ        | burst request held until controller acknowledges
//   BURST      | popping one FIFO word per controller data strobe
//   DONE       | one-cycle line-done pulse
module cap_line_writer
  import cap_line_writer_pkg::*;
#(
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int SCR_SIZE_BIT = SCR_SIZE_BIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  cap_line_writer_if.master bus
);

  localparam int CW = SCR_SIZE_BIT;
  localparam logic [31:0] BURST_LEN_W = 32'(BURST_LEN);

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q;
  logic [CW-1:0]     size_q;
  logic [CW-1:0]     col_q;
  logic [8:0]        len_q;
  logic [8:0]        wcnt_q;
  logic              overrun_q;

  logic [CW-1:0]     remain;
  logic [8:0]        len_calc;
  logic [CW-1:0]     col_next;
  logic              pop;
  logic              last_word;

  always_comb begin
    remain    = size_q - col_q;
    len_calc  = (32'(remain) >= BURST_LEN_W) ? 9'(BURST_LEN) : 9'(remain);
    col_next  = col_q + CW'(len_q);
    // Gated by reset so an abandoned burst cannot steal one more word.
    pop       = i_reset_n && (state_q == ST_BURST) && bus.i_data_next
                && (bus.i_fifo_usedw != 9'd0);
    last_word = pop && ((wcnt_q + 9'd1) == len_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_line_start) begin
          state_d = (bus.i_x_size != '0) ? ST_WAIT_DATA : ST_DONE;
        end
      end
      ST_WAIT_DATA: begin
        if (bus.i_fifo_usedw >= len_calc) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.i_burst_ack) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (last_word) state_d = (col_next == size_q) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      size_q    <= '0;
      col_q     <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.i_line_start && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_line_start && (bus.i_x_size != '0)) begin
            line_q <= bus.i_line;
            size_q <= bus.i_x_size;
            col_q  <= '0;
            wcnt_q <= '0;
          end
        end
        ST_WAIT_DATA: len_q <= len_calc;
        ST_BURST: begin
          if (last_word) begin
            wcnt_q <= '0;
            col_q  <= col_next;
          end else if (pop) begin
            wcnt_q <= wcnt_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_fifo_rdreq = pop;
  assign bus.o_burst_req  = (state_q == ST_REQ);
  assign bus.o_burst_addr = {line_q, col_q};
  assign bus.o_burst_len  = len_q;
  assign bus.o_wr_data    = {4'b0000, bus.i_fifo_data};
  assign bus.o_line_done  = (state_q == ST_DONE);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_cap_line_writer.sv
// Randomized bench for cap_line_writer: FIFO and SDRAM controller models plus a burst-plan scoreboard.
module tb_cap_line_writer;
  import cap_line_writer_pkg::*;

  localparam int BL = 8;
  localparam int SB = 12;

  typedef struct packed {
    logic [8:0]  line;
    logic [11:0] col;
    logic [8:0]  len;
  } burst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cap_line_writer_if #(.SCR_SIZE_BIT(SB)) bus ();

  cap_line_writer #(.BURST_LEN(BL), .SCR_SIZE_BIT(SB)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] fifo_q[$];
  burst_t      exp_bursts[$];
  bit          model_overrun = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected burst sequence: consecutive chunks of at most BL words across the line.
  function automatic void plan_line(input logic [8:0] line, input int size);
    int c = 0;
    int l;
    burst_t b;
    exp_bursts.delete();
    while (c < size) begin
      l = ((size - c) < BL) ? (size - c) : BL;
      b.line = line;
      b.col  = 12'(c);
      b.len  = 9'(l);
      exp_bursts.push_back(b);
      c += l;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_burst_req"}, bus.o_burst_req, 0);
    check({tag, "_fifo_rdreq"}, bus.o_fifo_rdreq, 0);
    check({tag, "_line_done"}, bus.o_line_done, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_overrun"}, bus.o_overrun, 0);
    check({tag, "_burst_addr"}, bus.o_burst_addr, 0);
    check({tag, "_burst_len"}, bus.o_burst_len, 0);
  endtask

  task automatic reset_mid_line();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_line_start = 1'b0;
    bus.i_burst_ack  = 1'b0;
    bus.i_data_next  = 1'b1;
    bus.i_fifo_usedw = 9'(fifo_q.size());
    #1;
    check("rst_cycle_rdreq", bus.o_fifo_rdreq, 0);
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_rdreq", bus.o_fifo_rdreq, 0);
      check("post_rst_busy", bus.o_busy, 0);
    end
    bus.i_data_next = 1'b0;
    fifo_q.delete();
    exp_bursts.delete();
    model_overrun = 1'b0;
  endtask

  task automatic run_line(input logic [8:0] line, input int size, input int prefill,
                          input int hold, input bit inj_ovr, input bit inj_rst);
    int to_push, pops, dones, done_cyc, cyc, ctl, ack_dly, words_left, prev_usedw;
    bit prev_req, ovr_done, finished, go_data, exp_rd;
    burst_t cur;
    to_push = size; pops = 0; dones = 0; done_cyc = -1; cyc = 0;
    ctl = 0; ack_dly = 0; words_left = 0; prev_usedw = 0;
    prev_req = 0; ovr_done = 0; finished = 0;
    plan_line(line, size);
    for (int k = 0; k < prefill; k++) begin
      fifo_q.push_back(12'($urandom));
      to_push--;
    end
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      if (cyc >= hold && to_push > 0 && $urandom_range(0, 2) != 0) begin
        fifo_q.push_back(12'($urandom));
        to_push--;
      end
      bus.i_line_start = (cyc == 0);
      bus.i_line       = line;
      bus.i_x_size     = SB'(size);
      bus.i_burst_ack  = 1'b0;
      bus.i_data_next  = 1'b0;
      go_data = 0;
      if (ctl == 0 && bus.o_burst_req) begin
        ctl = 1;
        ack_dly = $urandom_range(0, 2);
      end
      case (ctl)
        0: begin
          bus.i_data_next = ($urandom_range(0, 3) == 0);
          bus.i_burst_ack = ($urandom_range(0, 7) == 0);
        end
        1: begin
          if (ack_dly == 0) begin
            bus.i_burst_ack = 1'b1;
            go_data = 1;
          end else begin
            ack_dly--;
            bus.i_data_next = ($urandom_range(0, 3) == 0);
          end
        end
        default: begin
          bus.i_data_next = (fifo_q.size() != 0) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 3) == 0);
          bus.i_burst_ack = ($urandom_range(0, 7) == 0);
        end
      endcase
      if (inj_ovr && !ovr_done && ctl == 2) begin
        bus.i_line_start = 1'b1;
        bus.i_line       = ~line;
        bus.i_x_size     = SB'(5);
        ovr_done = 1;
        model_overrun = 1'b1;
      end
      bus.i_fifo_usedw = 9'(fifo_q.size());
      bus.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 12'h000;
      #1;
      exp_rd = (ctl == 2) && bus.i_data_next && (fifo_q.size() != 0);
      check("fifo_rdreq", bus.o_fifo_rdreq, exp_rd);
      if (cyc < hold) check("req_held_low", bus.o_burst_req, 0);
      if (bus.o_burst_req) begin
        if (exp_bursts.size() == 0) begin
          check("extra_burst_req", bus.o_burst_req, 0);
        end else begin
          check("burst_addr", bus.o_burst_addr, {exp_bursts[0].line, exp_bursts[0].col});
          check("burst_len", bus.o_burst_len, exp_bursts[0].len);
          if (!prev_req) check("req_fifo_level", (prev_usedw >= int'(exp_bursts[0].len)), 1);
          if (bus.i_burst_ack) begin
            cur = exp_bursts.pop_front();
            words_left = int'(cur.len);
          end
        end
      end
      if (bus.o_fifo_rdreq && fifo_q.size() != 0) begin
        check("wr_data", bus.o_wr_data, {4'h0, fifo_q[0]});
        void'(fifo_q.pop_front());
        pops++;
      end
      if (exp_rd) begin
        words_left--;
        if (words_left <= 0) ctl = 0;
      end
      if (go_data) ctl = 2;
      if (bus.o_line_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_usedw = int'(bus.i_fifo_usedw);
      prev_req   = bus.o_burst_req;
      if (inj_rst && pops == 3) begin
        reset_mid_line();
        return;
      end
      if (dones > 0 && cyc >= done_cyc + 3) finished = 1;
      cyc++;
    end
    bus.i_data_next = 1'b0;
    bus.i_burst_ack = 1'b0;
    bus.i_line_start = 1'b0;
    check("line_finished", finished, 1);
    check("pop_count", pops, size);
    check("bursts_left", exp_bursts.size(), 0);
    check("line_done_count", dones, 1);
    if (size == 0) check("zero_size_done_latency", done_cyc, 1);
    check("overrun", bus.o_overrun, model_overrun);
    check("busy_after_line", bus.o_busy, 0);
  endtask

  initial begin
    int sz;
    bus.i_line_start = 1'b0;
    bus.i_line       = '0;
    bus.i_x_size     = '0;
    bus.i_fifo_data  = '0;
    bus.i_fifo_usedw = '0;
    bus.i_burst_ack  = 1'b0;
    bus.i_data_next  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_line(9'd5, 16, 16, 0, 1'b0, 1'b0);
    run_line(9'd300, 13, 13, 0, 1'b0, 1'b0);
    run_line(9'd7, 8, 5, 20, 1'b0, 1'b0);
    run_line(9'd1, 0, 0, 0, 1'b0, 1'b0);
    run_line(9'd44, 24, 24, 0, 1'b1, 1'b0);
    run_line(9'd45, 9, 2, 0, 1'b0, 1'b0);
    run_line(9'd2, 16, 16, 0, 1'b0, 1'b1);
    run_line(9'd3, 7, 7, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      sz = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
      run_line(9'($urandom), sz, $urandom_range(0, sz), 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
